// File: rtl/ddr_aw_scheduler.sv
// AXI write-address scheduler: pops burst addresses from a prefetch FIFO and issues them on AW,
// bounded by an outstanding-B-response credit. Optional 4 KB-crossing filter: DDR_AW_4K_CHECK_EN.
module ddr_aw_scheduler #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned BURST_LEN       = 16,
    parameter int unsigned BEAT_BYTES      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_rd_vld,
    input  logic [ADDR_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic                  awvalid,
    input  logic                  awready,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [3:0]            outstanding,
    output logic [15:0]           aw_cnt,
    output logic                  err_4k,
    output logic                  idle
);

    localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [3:0]              outstanding_q, outstanding_d;
    logic [CNT_W-1:0]        aw_cnt_q, aw_cnt_d;
    logic                    pop_c;
    logic                    hs_c;
    logic                    dec_c;
    logic                    cross_4k_c;

`ifdef DDR_AW_4K_CHECK_EN
    logic err_4k_q, err_4k_d;
    assign cross_4k_c = (32'(fifo_rd_data[11:0]) + 32'(BURST_BYTES)) > 32'd4096;
`else
    assign cross_4k_c = 1'b0;
`endif

    // Credit check uses the registered count, so popping resumes the cycle after a decrement.
    assign pop_c = (state_q == IDLE) && enable && fifo_rd_vld
                   && (outstanding_q < 4'(MAX_OUTSTANDING));
    assign hs_c  = (state_q == ISSUE) && awready;
    assign dec_c = bvalid && (outstanding_q != 4'd0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d       = state_q;
        awaddr_d      = awaddr_q;
        outstanding_d = outstanding_q;
        aw_cnt_d      = aw_cnt_q;
`ifdef DDR_AW_4K_CHECK_EN
        err_4k_d      = err_4k_q;
`endif
        case (state_q)
            IDLE: begin
                if (pop_c) begin
                    if (cross_4k_c) begin
`ifdef DDR_AW_4K_CHECK_EN
                        err_4k_d = 1'b1;
`endif
                    end else begin
                        awaddr_d = fifo_rd_data;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (awready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (hs_c) begin
            aw_cnt_d = aw_cnt_q + 16'd1;
        end
        if (hs_c && !dec_c) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (dec_c && !hs_c) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awaddr_q      <= '0;
            outstanding_q <= 4'd0;
            aw_cnt_q      <= 16'd0;
        end else begin
            awaddr_q      <= awaddr_d;
            outstanding_q <= outstanding_d;
            aw_cnt_q      <= aw_cnt_d;
        end
    end

`ifdef DDR_AW_4K_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_4k_q <= 1'b0;
        end else begin
            err_4k_q <= err_4k_d;
        end
    end
    assign err_4k = err_4k_q;
`else
    assign err_4k = 1'b0;
`endif

    assign fifo_rd_en  = pop_c;
    assign awaddr      = awaddr_q;
    assign awlen       = 8'(BURST_LEN - 1);
    assign awvalid     = (state_q == ISSUE);
    assign bready      = rst_n;
    assign outstanding = outstanding_q;
    assign aw_cnt      = aw_cnt_q;
    assign idle        = (state_q == IDLE) && (outstanding_q == 4'd0);

endmodule
